// File: rtl/router_pkg.sv
// Shared definitions for the slave read-issue block.
//   TAG_W            : width of the routing tag carried with every read
//   TAG_*_HI/LO      : bit positions of master id, slave id and sequence fields
//   rd_state_e       : read-issue FSM state encoding
//   rr_pick()        : 4-way round-robin selector used for master grants
package router_pkg;

  localparam int TAG_W      = 7;
  localparam int TAG_MID_HI = 6;
  localparam int TAG_MID_LO = 5;
  localparam int TAG_SID_HI = 4;
  localparam int TAG_SID_LO = 3;
  localparam int TAG_SEQ_HI = 2;
  localparam int TAG_SEQ_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2
  } rd_state_e;

  // Returns {found, index}. The search starts at last+1 and wraps, so the
  // most recently granted master has the lowest priority next time.
  function automatic logic [2:0] rr_pick(input logic [3:0] elig,
                                         input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!res[2] && elig[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/tag_fifo.sv
// Synchronous FIFO holding the tags of reads issued to the slave and not yet
// answered. The head entry is visible combinationally on head_o.
//   clk_i, rst_i  : clock, synchronous active-high reset (empties the FIFO)
//   push_i, din_i : write a tag (ignored when full)
//   pop_i         : drop the head entry (ignored when empty)
//   head_o        : oldest stored tag
//   full_o/empty_o: occupancy flags
//   count_o       : number of stored entries, 0..DEPTH
module tag_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/slave_rd_issue.sv
// Issues read commands from four masters to one slave and returns the tagged,
// in-order read responses to the downstream router stage.
//   clk, rst                        : clock, synchronous active-high reset
//   m_req, m_addr_N, m_tag_N        : per-master read requests (held until m_ack)
//   m_ack                           : one-hot single-cycle acceptance pulse
//   s_req, s_addr, s_ack            : command channel to the slave
//   s_resp, s_rdata                 : in-order read responses from the slave
//   resp, data_in_buf_router,
//   addr_in_buf_router              : tagged response to the downstream stage
//   outstanding                     : reads issued and not yet answered
//   err_orphan                      : sticky, a response arrived with nothing outstanding
//   dbg_state                       : current FSM state (rd_state_e encoding)
//
// Command handshake: s_req rises with s_addr valid and both stay stable until
// the cycle where s_ack is sampled high; the command is accepted on that edge
// and s_req drops. m_ack is the matching acceptance towards the master.
module slave_rd_issue
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SLAVE_N    = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    m_req,
  input  logic [ADDR_WIDTH-1:0]         m_addr_0,
  input  logic [ADDR_WIDTH-1:0]         m_addr_1,
  input  logic [ADDR_WIDTH-1:0]         m_addr_2,
  input  logic [ADDR_WIDTH-1:0]         m_addr_3,
  input  logic [TAG_W-1:0]              m_tag_0,
  input  logic [TAG_W-1:0]              m_tag_1,
  input  logic [TAG_W-1:0]              m_tag_2,
  input  logic [TAG_W-1:0]              m_tag_3,
  output logic [3:0]                    m_ack,
  output logic                          s_req,
  output logic [ADDR_WIDTH-1:0]         s_addr,
  input  logic                          s_ack,
  input  logic                          s_resp,
  input  logic [DATA_WIDTH-1:0]         s_rdata,
  output logic                          resp,
  output logic [DATA_WIDTH-1:0]         data_in_buf_router,
  output logic [TAG_W-1:0]              addr_in_buf_router,
  output logic [$clog2(FIFO_DEPTH):0]   outstanding,
  output logic                          err_orphan,
  output logic [1:0]                    dbg_state
);

  localparam logic [1:0] SLAVE_ID = 2'(SLAVE_N);

  rd_state_e             state_q, state_d;
  logic [1:0]            last_grant_q, last_grant_d;
  logic [1:0]            grant_q, grant_d;
  logic                  s_req_q, s_req_d;
  logic [ADDR_WIDTH-1:0] s_addr_q, s_addr_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [3:0]            m_ack_q, m_ack_d;

  logic                  resp_q, resp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [TAG_W-1:0]      rtag_q, rtag_d;
  logic                  orphan_q, orphan_d;

  logic [ADDR_WIDTH-1:0] addr_arr [4];
  logic [TAG_W-1:0]      tag_arr  [4];
  logic [3:0]            elig;
  logic [2:0]            pick;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [TAG_W-1:0]      fifo_head;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  always_comb begin
    addr_arr[0] = m_addr_0;
    addr_arr[1] = m_addr_1;
    addr_arr[2] = m_addr_2;
    addr_arr[3] = m_addr_3;
    tag_arr[0]  = m_tag_0;
    tag_arr[1]  = m_tag_1;
    tag_arr[2]  = m_tag_2;
    tag_arr[3]  = m_tag_3;
  end

  // A master competes only when its request targets this slave.
  always_comb begin
    elig = '0;
    for (int i = 0; i < 4; i++) begin
      elig[i] = m_req[i] && (tag_arr[i][TAG_SID_HI:TAG_SID_LO] == SLAVE_ID);
    end
  end

  assign pick = rr_pick(elig, last_grant_q);

  // Command FSM
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    s_req_d      = s_req_q;
    s_addr_d     = s_addr_q;
    tag_d        = tag_q;
    m_ack_d      = '0;
    fifo_push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Full FIFO blocks new grants so outstanding never exceeds the depth.
        if (pick[2] && !fifo_full) begin
          grant_d      = pick[1:0];
          last_grant_d = pick[1:0];
          s_addr_d     = addr_arr[pick[1:0]];
          tag_d        = tag_arr[pick[1:0]];
          s_req_d      = 1'b1;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (s_ack) begin
          s_req_d   = 1'b0;
          fifo_push = 1'b1;
          m_ack_d   = 4'b0001 << grant_q;
          state_d   = ST_ACK;
        end
      end
      ST_ACK: begin
        // m_ack_d defaults to zero, so the acknowledge is a single pulse.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response path: responses arrive in issue order, so the head tag matches.
  always_comb begin
    fifo_pop = s_resp && !fifo_empty;
    resp_d   = fifo_pop;
    rdata_d  = rdata_q;
    rtag_d   = rtag_q;
    orphan_d = orphan_q | (s_resp && fifo_empty);
    if (fifo_pop) begin
      rdata_d = s_rdata;
      rtag_d  = fifo_head;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 2'd3;
      grant_q      <= 2'd0;
      s_req_q      <= 1'b0;
      s_addr_q     <= '0;
      tag_q        <= '0;
      m_ack_q      <= '0;
      resp_q       <= 1'b0;
      rdata_q      <= '0;
      rtag_q       <= '0;
      orphan_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      s_req_q      <= s_req_d;
      s_addr_q     <= s_addr_d;
      tag_q        <= tag_d;
      m_ack_q      <= m_ack_d;
      resp_q       <= resp_d;
      rdata_q      <= rdata_d;
      rtag_q       <= rtag_d;
      orphan_q     <= orphan_d;
    end
  end

  tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .din_i   (tag_q),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign m_ack              = m_ack_q;
  assign s_req              = s_req_q;
  assign s_addr             = s_addr_q;
  assign resp               = resp_q;
  assign data_in_buf_router = rdata_q;
  assign addr_in_buf_router = rtag_q;
  assign outstanding        = fifo_count;
  assign err_orphan         = orphan_q;
  assign dbg_state          = state_q;

endmodule

// File: doc/slave_rd_issue.md
SLAVE_RD_ISSUE -- requirements
Module: slave_rd_issue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, read data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, read address width.
REQ-003 SHALL have parameter SLAVE_N, default 0, 2-bit index of the served slave.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, power of two, maximum outstanding reads.
REQ-005 Port clk, input, 1: single clock; all logic on posedge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port m_req, input, 4: per-master read request; held until that master's m_ack.
REQ-008 Ports m_addr_0..m_addr_3, input, ADDR_WIDTH each: per-master read address.
REQ-009 Ports m_tag_0..m_tag_3, input, 7 each: tag; [6:5] master id, [4:3] slave id, [2:0] sequence.
REQ-010 Port m_ack, output, 4: one-hot, single-cycle acceptance pulse.
REQ-011 Ports s_req (output, 1) and s_addr (output, ADDR_WIDTH): command to the slave.
REQ-012 Port s_ack, input, 1: slave accepts the command.
REQ-013 Ports s_resp (input, 1) and s_rdata (input, DATA_WIDTH): in-order slave read response.
REQ-014 Ports resp (output, 1), data_in_buf_router (output, DATA_WIDTH), addr_in_buf_router (output, 7): tagged response to the downstream round-robin read stage.
REQ-015 Ports outstanding (output, $clog2(FIFO_DEPTH)+1) and err_orphan (output, 1, sticky).

Function
REQ-016 Eligible master: m_req[i]=1 and m_tag_i[4:3]==SLAVE_N; all others are ignored.
REQ-017 FSM states: IDLE, ISSUE, ACK.
REQ-018 IDLE: when a master is eligible and the FIFO is not full, grant it, register s_addr and tag, set s_req=1, go to ISSUE.
REQ-019 Grant order: round-robin, starting from last_grant+1 mod 4; last_grant updates on grant.
REQ-020 IDLE with FIFO full: no grant; s_req stays 0.
REQ-021 ISSUE: hold s_req=1 and s_addr stable until s_ack=1; on that edge clear s_req, push the tag into the FIFO, set m_ack[grant]=1, go to ACK.
REQ-022 ACK: lasts exactly one cycle with m_ack asserted; m_ack clears and FSM returns to IDLE.
REQ-023 The earliest regrant of the same master is the IDLE cycle after ACK.
REQ-024 s_resp=1 with FIFO non-empty: pop the head tag; next cycle drive resp=1, addr_in_buf_router=tag, data_in_buf_router=s_rdata.
REQ-025 resp is a one-cycle pulse per s_resp; back-to-back s_resp yields back-to-back resp.
REQ-026 data_in_buf_router and addr_in_buf_router hold their values while resp=0.
REQ-027 s_resp with FIFO empty: no resp, no pop; err_orphan set to 1 until reset.
REQ-028 Simultaneous push and pop: outstanding is unchanged, and the popped tag is the old head.
REQ-029 outstanding equals the FIFO occupancy; it never exceeds FIFO_DEPTH, and FIFO pointers wrap modulo FIFO_DEPTH.

Reset
REQ-030 rst SHALL set, on the next edge: state=IDLE, last_grant=3, s_req=0, s_addr=0, m_ack=0, resp=0, data_in_buf_router=0, addr_in_buf_router=0, FIFO empty, outstanding=0, err_orphan=0.
REQ-031 rst mid-operation (ISSUE or ACK, or FIFO non-empty) SHALL abandon all in-flight commands and issue no m_ack or resp for them.

Structure
REQ-032 Package router_pkg SHALL hold TAG_W=7, the tag field bit positions, and the FSM state enum.
REQ-033 The tag FIFO SHALL be a separate sub-module tag_fifo (synchronous, push/pop/full/empty/count).

Verification
REQ-034 Reset, then m_req=4'b0001, m_tag_0=7'h00 (SLAVE_N=0), s_ack one cycle after s_req -> s_req for 2 cycles, m_ack=4'b0001 for one cycle, outstanding=1.
REQ-035 All four masters request slave 0 simultaneously -> grant order 0,1,2,3, then 0 again.
REQ-036 m_req=4'b0010 with m_tag_1[4:3]=2'b01, SLAVE_N=0 -> s_req never asserted, m_ack stays 0.
REQ-037 Issue 8 reads with no s_resp -> outstanding=8 and a 9th request is not granted; one s_resp -> outstanding=7 and the 9th is granted.
REQ-038 Tags 7'h00, 7'h20, 7'h40 issued; s_resp with rdata A, B, C on consecutive cycles -> resp for 3 consecutive cycles with addr_in_buf_router 00, 20, 40 and data A, B, C.
REQ-039 s_resp while empty -> err_orphan=1 and resp=0; rst asserted during ISSUE -> s_req=0 after the next edge, no m_ack.
